focus_metric_accum: RTL and testbench

Downstream consumer of the filter stage's registered VGA output. It takes the per-pixel edge magnitude on the gray channel (Sobel mode: R=G=B) and accumulates thresholded edge energy over a centred region of interest (ROI), producing one sharpness score per frame. A sweep FSM then steps the camera focus position through a req/ack handshake to the focus driver and reports the sharpest position. Intended use: KEY[3] starts a sweep; SW[9] enables auto-focus.

---
 rtl/focus_metric_accum.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_focus_metric_accum.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/focus_metric_accum.sv
// focus_metric_accum
//
// Purpose:
//   Scores image sharpness from the filter stage's registered VGA output. The
//   edge magnitude (gray channel) is thresholded and summed over a centred
//   region of interest. This produces one saturating score per frame. A sweep
//   FSM steps the focus position through a req/ack handshake with the focus
//   driver. It records the sharpest position and then parks the lens there.
//
// Build option:
//   FOCUS_TIMEOUT_EN - when defined, a request without an ack for TIMEOUT
//                      cycles aborts the sweep and sets the sticky error flag.
//                      When undefined, requests wait forever and error is 0.
//
// Ports:
//   VGA_CLK       in   pixel clock
//   reset         in   synchronous, active-high reset
//   iEDGE         in   edge magnitude (filter red channel)
//   iVGA_HS       in   horizontal sync, low between lines
//   iVGA_VS       in   vertical sync, low between frames
//   iVGA_BLANK_N  in   high during active pixels
//   enable        in   auto-focus mode; low forces the FSM to idle
//   start         in   one-cycle pulse that begins a sweep
//   focus_ack     in   focus driver accepted focus_pos
//   frame_score   out  last completed frame's score
//   score_valid   out  one-cycle pulse when frame_score updates
//   best_score    out  best score in the current or last sweep
//   best_pos      out  position of best_score
//   focus_pos     out  requested focus position
//   focus_req     out  request to the focus driver
//   busy          out  FSM not idle
//   done          out  one-cycle pulse when a sweep completes
//   error         out  sticky ack-timeout flag
module focus_metric_accum #(
    parameter int unsigned WIDTH         = 800,
    parameter int unsigned HEIGHT        = 480,
    parameter int unsigned ROI_MARGIN    = 16,
    parameter int unsigned THRESH        = 8,
    parameter int unsigned SUM_BITS      = 32,
    parameter int unsigned POS_BITS      = 10,
    parameter int unsigned MAX_POS       = 1023,
    parameter int unsigned STEP          = 64,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned TIMEOUT       = 1000000
) (
    input  logic                VGA_CLK,
    input  logic                reset,
    input  logic [7:0]          iEDGE,
    input  logic                iVGA_HS,
    input  logic                iVGA_VS,
    input  logic                iVGA_BLANK_N,
    input  logic                enable,
    input  logic                start,
    input  logic                focus_ack,
    output logic [SUM_BITS-1:0] frame_score,
    output logic                score_valid,
    output logic [SUM_BITS-1:0] best_score,
    output logic [POS_BITS-1:0] best_pos,
    output logic [POS_BITS-1:0] focus_pos,
    output logic                focus_req,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int unsigned XW = $clog2(WIDTH + 1);
    localparam int unsigned YW = $clog2(HEIGHT + 1);
    localparam int unsigned SW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

    localparam logic [XW-1:0]       XLo       = XW'(ROI_MARGIN);
    localparam logic [XW-1:0]       XHi       = XW'(WIDTH - ROI_MARGIN);
    localparam logic [YW-1:0]       YLo       = YW'(ROI_MARGIN);
    localparam logic [YW-1:0]       YHi       = YW'(HEIGHT - ROI_MARGIN);
    localparam logic [7:0]          Thresh    = 8'(THRESH);
    localparam logic [POS_BITS:0]   StepWide  = (POS_BITS + 1)'(STEP);
    localparam logic [POS_BITS:0]   MaxWide   = (POS_BITS + 1)'(MAX_POS);
    localparam logic [POS_BITS-1:0] StepPos   = POS_BITS'(STEP);
    localparam logic [SW-1:0]       SettleEnd = SW'(SETTLE_FRAMES - 1);

    // ------------------------------------------------------------------
    // Input registers and edge detection
    // ------------------------------------------------------------------
    logic [7:0] edge_q;
    logic       hs_q, vs_q, blank_q;
    logic       hs_prev_q, vs_prev_q, blank_prev_q;

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            edge_q       <= '0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            blank_q      <= 1'b0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            blank_prev_q <= 1'b0;
        end else begin
            edge_q       <= iEDGE;
            hs_q         <= iVGA_HS;
            vs_q         <= iVGA_VS;
            blank_q      <= iVGA_BLANK_N;
            hs_prev_q    <= hs_q;
            vs_prev_q    <= vs_q;
            blank_prev_q <= blank_q;
        end
    end

    logic hs_fall, vs_fall, blank_fall;

    assign hs_fall    = hs_prev_q & ~hs_q;
    assign vs_fall    = vs_prev_q & ~vs_q;
    assign blank_fall = blank_prev_q & ~blank_q;

    // ------------------------------------------------------------------
    // Pixel position counters and ROI accumulator
    // ------------------------------------------------------------------
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [SUM_BITS-1:0] sum_q, sum_d;
    logic [SUM_BITS-1:0] frame_score_q, frame_score_d;
    logic                score_valid_q, score_valid_d;
    logic [SUM_BITS:0]   sum_ext;
    logic                in_roi;
    logic                acc_en;

    always_comb begin
        in_roi  = (x_q >= XLo) && (x_q < XHi) && (y_q >= YLo) && (y_q < YHi);
        acc_en  = blank_q && in_roi && (edge_q >= Thresh);
        sum_ext = {1'b0, sum_q} + {{(SUM_BITS - 7){1'b0}}, edge_q};

        // Counters hold at all-ones so an overlong line or frame cannot wrap
        // back into the ROI.
        x_d = x_q;
        if (hs_fall) begin
            x_d = '0;
        end else if (blank_q && (x_q != '1)) begin
            x_d = x_q + XW'(1);
        end

        y_d = y_q;
        if (vs_fall) begin
            y_d = '0;
        end else if (blank_fall && (y_q != '1)) begin
            y_d = y_q + YW'(1);
        end

        sum_d         = sum_q;
        frame_score_d = frame_score_q;
        score_valid_d = 1'b0;
        if (vs_fall) begin
            frame_score_d = sum_q;
            sum_d         = '0;
            score_valid_d = 1'b1;
        end else if (acc_en) begin
            sum_d = sum_ext[SUM_BITS] ? '1 : sum_ext[SUM_BITS-1:0];
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            sum_q         <= '0;
            frame_score_q <= '0;
            score_valid_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            sum_q         <= sum_d;
            frame_score_q <= frame_score_d;
            score_valid_q <= score_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Focus sweep FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        StIdle,
        StMove,
        StSettle,
        StMeasure,
        StCompare,
        StFinalMove,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [POS_BITS-1:0] pos_q, pos_d;
    logic [POS_BITS-1:0] focus_pos_q, focus_pos_d;
    logic [POS_BITS-1:0] best_pos_q, best_pos_d;
    logic [SUM_BITS-1:0] best_score_q, best_score_d;
    logic [SUM_BITS-1:0] meas_q, meas_d;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic                last_pos;

`ifdef FOCUS_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] ToLast = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          error_q, error_d;
`endif

    // Evaluated as pos > MAX_POS - STEP without underflow.
    assign last_pos = ({1'b0, pos_q} + StepWide) > MaxWide;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        focus_pos_d  = focus_pos_q;
        best_pos_d   = best_pos_q;
        best_score_d = best_score_q;
        meas_d       = meas_q;
        settle_cnt_d = settle_cnt_q;
`ifdef FOCUS_TIMEOUT_EN
        to_cnt_d     = '0;
        error_d      = error_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start && enable) begin
                    pos_d        = '0;
                    focus_pos_d  = '0;
                    best_pos_d   = '0;
                    best_score_d = '0;
                    settle_cnt_d = '0;
`ifdef FOCUS_TIMEOUT_EN
                    error_d      = 1'b0;
`endif
                    state_d      = StMove;
                end
            end
            StMove: begin
                if (focus_ack) begin
                    settle_cnt_d = '0;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                // Discarded frames flush any frame that straddled the move.
                if (score_valid_q) begin
                    if (settle_cnt_q == SettleEnd) begin
                        state_d = StMeasure;
                    end else begin
                        settle_cnt_d = settle_cnt_q + SW'(1);
                    end
                end
            end
            StMeasure: begin
                if (score_valid_q) begin
                    meas_d  = frame_score_q;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                // Strict compare: ties keep the earlier (lower) position.
                if (meas_q > best_score_q) begin
                    best_score_d = meas_q;
                    best_pos_d   = pos_q;
                end
                if (last_pos) begin
                    focus_pos_d = best_pos_d;
                    state_d     = StFinalMove;
                end else begin
                    pos_d       = pos_q + StepPos;
                    focus_pos_d = pos_q + StepPos;
                    state_d     = StMove;
                end
            end
            StFinalMove: begin
                if (focus_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef FOCUS_TIMEOUT_EN
        if (focus_req && !focus_ack) begin
            if (to_cnt_q == ToLast) begin
                state_d = StIdle;
                error_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
`endif

        // Leaving auto-focus mode aborts immediately and keeps partial best_*.
        if (!enable) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            state_q      <= StIdle;
            pos_q        <= '0;
            focus_pos_q  <= '0;
            best_pos_q   <= '0;
            best_score_q <= '0;
            meas_q       <= '0;
            settle_cnt_q <= '0;
`ifdef FOCUS_TIMEOUT_EN
            to_cnt_q     <= '0;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            focus_pos_q  <= focus_pos_d;
            best_pos_q   <= best_pos_d;
            best_score_q <= best_score_d;
            meas_q       <= meas_d;
            settle_cnt_q <= settle_cnt_d;
`ifdef FOCUS_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            error_q      <= error_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign frame_score = frame_score_q;
    assign score_valid = score_valid_q;
    assign best_score  = best_score_q;
    assign best_pos    = best_pos_q;
    assign focus_pos   = focus_pos_q;
    assign focus_req   = (state_q == StMove) || (state_q == StFinalMove);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

`ifdef FOCUS_TIMEOUT_EN
    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_focus_metric_accum.sv
`timescale 1ns/1ps
module tb_focus_metric_accum;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int M  = 2;
    localparam int TH = 8;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       reset, hs, vs, blank, enable, start, ack;
    logic [7:0] pix;

    logic [31:0] frame_score, best_score;
    logic        score_valid, focus_req, busy, done, error;
    logic [9:0]  best_pos, focus_pos;

    logic [7:0]  frame_score8, best_score8;
    logic        score_valid8, focus_req8, busy8, done8, error8;
    logic [9:0]  best_pos8, focus_pos8;

    focus_metric_accum #(
        .WIDTH(W), .HEIGHT(H), .ROI_MARGIN(M), .THRESH(TH), .SUM_BITS(32), .TIMEOUT(100)
    ) dut (
        .VGA_CLK(clk), .reset(reset), .iEDGE(pix), .iVGA_HS(hs), .iVGA_VS(vs),
        .iVGA_BLANK_N(blank), .enable(enable), .start(start), .focus_ack(ack),
        .frame_score(frame_score), .score_valid(score_valid), .best_score(best_score),
        .best_pos(best_pos), .focus_pos(focus_pos), .focus_req(focus_req), .busy(busy),
        .done(done), .error(error)
    );

    focus_metric_accum #(
        .WIDTH(W), .HEIGHT(H), .ROI_MARGIN(M), .THRESH(TH), .SUM_BITS(8)
    ) dut8 (
        .VGA_CLK(clk), .reset(reset), .iEDGE(pix), .iVGA_HS(hs), .iVGA_VS(vs),
        .iVGA_BLANK_N(blank), .enable(enable), .start(start), .focus_ack(ack),
        .frame_score(frame_score8), .score_valid(score_valid8), .best_score(best_score8),
        .best_pos(best_pos8), .focus_pos(focus_pos8), .focus_req(focus_req8), .busy(busy8),
        .done(done8), .error(error8)
    );

    int ntests = 0;
    int nfail  = 0;
    int frame_pix [H][W];
    int cur_pos    = 0;
    int gen_mode   = 0;
    bit gen_run    = 1'b0;
    bit ack_en     = 1'b0;
    int done_cnt   = 0;
    int req_cycles = 0;
    int req_pos0   = 0;
    int hs_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int shape_val(int sh, int p);
        int d;
        d = (p > 320) ? p - 320 : 320 - p;
        if (sh == 3) return 200 - d / 8;
        return (p == 128 || p == 192) ? 150 : 100;
    endfunction

    // 0: constant, 1: edges only in columns 0/1, 2: random, 3/4: focus-dependent
    function automatic int pix_val(int mode, int val, int x);
        case (mode)
            0:       return val;
            1:       return (x < 2) ? 200 : 0;
            2:       return int'($urandom_range(0, 255));
            default: return shape_val(mode, cur_pos);
        endcase
    endfunction

    function automatic int roi_count();
        int n = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (x >= M && x < W - M && y >= M && y < H - M) n++;
        return n;
    endfunction

    function automatic longint model_score(int bits);
        longint s   = 0;
        longint lim = (longint'(1) << bits) - 1;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (x >= M && x < W - M && y >= M && y < H - M && frame_pix[y][x] >= TH) begin
                    s += frame_pix[y][x];
                    if (s > lim) s = lim;
                end
        return s;
    endfunction

    task automatic drive_lines(input int mode, input int val);
        for (int y = 0; y < H; y++) begin
            hs = 1'b0; tick(); tick();
            hs = 1'b1; tick(); tick();
            blank = 1'b1;
            for (int x = 0; x < W; x++) begin
                int v;
                v = pix_val(mode, val, x);
                frame_pix[y][x] = v;
                pix = 8'(v);
                tick();
            end
            blank = 1'b0; pix = '0;
            tick(); tick();
        end
    endtask

    task automatic frame_check(input string tag);
        longint e32, e8;
        e32 = model_score(32);
        e8  = model_score(8);
        vs = 1'b0;
        tick();
        check({tag, "_sv_early"}, 64'(score_valid), 0);
        tick();
        check({tag, "_sv"}, 64'(score_valid), 1);
        check({tag, "_score"}, 64'(frame_score), e32);
        check({tag, "_score8"}, 64'(frame_score8), e8);
        tick();
        check({tag, "_sv_once"}, 64'(score_valid), 0);
        vs = 1'b1;
        tick();
    endtask

    task automatic run_sweep(input int shape, input string tag, input int lit_best);
        longint exp_best, sc;
        int     exp_pos, budget, n;
        int     exp_seq[$];
        bit     pulsed;
        exp_best = 0; exp_pos = 0; pulsed = 1'b0;
        for (int p = 0; p <= 1023; p += 64) begin
            exp_seq.push_back(p);
            sc = longint'(roi_count()) * shape_val(shape, p);
            if (sc > exp_best) begin
                exp_best = sc;
                exp_pos  = p;
            end
        end
        exp_seq.push_back(exp_pos);
        gen_mode = shape; hs_log.delete(); done_cnt = 0;
        enable = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        budget = 40000;
        while (done_cnt == 0 && budget > 0) begin
            tick();
            budget--;
            if (!pulsed && hs_log.size() == 5) begin
                pulsed = 1'b1;
                start = 1'b1; tick(); start = 1'b0;
            end
        end
        repeat (3) tick();
        check({tag, "_done_once"}, 64'(done_cnt), 1);
        check({tag, "_busy_end"}, 64'(busy), 0);
        check({tag, "_handshakes"}, 64'(hs_log.size()), 64'(exp_seq.size()));
        n = (hs_log.size() < exp_seq.size()) ? hs_log.size() : exp_seq.size();
        for (int i = 0; i < n; i++) check({tag, "_pos_seq"}, 64'(hs_log[i]), 64'(exp_seq[i]));
        check({tag, "_best_pos"}, 64'(best_pos), 64'(exp_pos));
        check({tag, "_best_pos_lit"}, 64'(best_pos), 64'(lit_best));
        check({tag, "_best_score"}, 64'(best_score), exp_best);
        check({tag, "_focus_pos"}, 64'(focus_pos), 64'(exp_pos));
    endtask

    initial begin
        int budget;
        reset = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0; pix = '0;
        enable = 1'b0; start = 1'b0; ack = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) frame_pix[y][x] = 0;
        repeat (3) tick();
        check("rst_frame_score", 64'(frame_score), 0);
        check("rst_score_valid", 64'(score_valid), 0);
        check("rst_best_score", 64'(best_score), 0);
        check("rst_best_pos", 64'(best_pos), 0);
        check("rst_focus_pos", 64'(focus_pos), 0);
        check("rst_focus_req", 64'(focus_req), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_error", 64'(error), 0);
        reset = 1'b0;
        tick(); tick();

        frame_check("prime");
        drive_lines(0, 10);  frame_check("const10");
        check("const10_lit", 64'(frame_score), 480);
        drive_lines(0, 5);   frame_check("below_thresh");
        check("below_thresh_lit", 64'(frame_score), 0);
        drive_lines(1, 0);   frame_check("cols01");
        check("cols01_lit", 64'(frame_score), 0);
        drive_lines(0, 255); frame_check("sat");
        check("sat8_lit", 64'(frame_score8), 255);
        check("sat32_lit", 64'(frame_score), 12240);
        for (int i = 0; i < 3; i++) begin
            drive_lines(2, 0);
            frame_check("rand");
        end

        gen_run = 1'b1; ack_en = 1'b1; gen_mode = 3;
        fork
            begin
                while (gen_run) begin
                    vs = 1'b0; repeat (3) tick();
                    vs = 1'b1; repeat (2) tick();
                    drive_lines(gen_mode, 0);
                end
            end
            begin
                forever begin
                    tick();
                    if (ack) begin
                        ack = 1'b0;
                    end else if (focus_req && ack_en) begin
                        if (req_cycles == 0) req_pos0 = int'(focus_pos);
                        req_cycles++;
                        if (req_cycles == 3) begin
                            check("req_pos_stable", 64'(focus_pos), 64'(req_pos0));
                            hs_log.push_back(int'(focus_pos));
                            cur_pos    = int'(focus_pos);
                            ack        = 1'b1;
                            req_cycles = 0;
                        end
                    end else begin
                        req_cycles = 0;
                    end
                end
            end
            begin
                forever begin
                    @(negedge clk);
                    if (done) done_cnt++;
                end
            end
        join_none

        run_sweep(3, "peak", 320);
        run_sweep(4, "tie", 128);

        // Abort by dropping enable while settling.
        gen_mode = 3; hs_log.delete(); done_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        budget = 200;
        while (hs_log.size() == 0 && budget > 0) begin tick(); budget--; end
        check("abort_first_ack", 64'(hs_log.size()), 1);
        repeat (5) tick();
        check("abort_busy_before", 64'(busy), 1);
        enable = 1'b0;
        tick();
        check("abort_req", 64'(focus_req), 0);
        check("abort_busy", 64'(busy), 0);
        repeat (20) tick();
        check("abort_no_done", 64'(done_cnt), 0);

        // Driver never acknowledges.
        ack_en = 1'b0; enable = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
`ifdef FOCUS_TIMEOUT_EN
        repeat (89) tick();
        check("to_req_held", 64'(focus_req), 1);
        check("to_err_clear", 64'(error), 0);
        repeat (15) tick();
        check("to_req_dropped", 64'(focus_req), 0);
        check("to_err_set", 64'(error), 1);
        check("to_idle", 64'(busy), 0);
        start = 1'b1; tick(); start = 1'b0;
        check("to_err_cleared_by_start", 64'(error), 0);
        check("to_restart_req", 64'(focus_req), 1);
`else
        repeat (1000) tick();
        check("noto_req_held", 64'(focus_req), 1);
        check("noto_err", 64'(error), 0);
        check("noto_busy", 64'(busy), 1);
`endif

        // Reset while a request is outstanding.
        reset = 1'b1;
        tick();
        check("midrst_req", 64'(focus_req), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_frame_score", 64'(frame_score), 0);
        check("midrst_focus_pos", 64'(focus_pos), 0);
        check("midrst_error", 64'(error), 0);
        reset = 1'b0;
        gen_run = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
